// File: rtl/stack_push_pop_sequencer.sv
// stack_push_pop_sequencer
//   Multi-cycle stack sequencer for CALL/INT pushes and RET/RTI pops in the
//   memory stage. It drives the PC/flags forwarding mux selects, the
//   data-memory address and strobes, and the stack pointer. busy stalls the
//   pipeline while a sequence is running.
//
//   Optional feature macro: STACK_BOUNDS_CHECK_EN
//     When it is defined, a push with sp==0 or a pop with sp==SP_RESET faults.
//     The access is suppressed, stack_fault pulses for one cycle, and the
//     sequence aborts to IDLE. When it is undefined, the stack_fault port is
//     absent and SP wraps silently.
//
//   Ports
//     clk, rst        rising-edge clock, synchronous active-high reset
//     int_req         push PCH, PCL, flags
//     call_req        push PCH, PCL
//     rti_req         pop flags, PCL, PCH
//     ret_req         pop PCL, PCH
//     mem_rdata       read data, valid one cycle after mem_re
//     sp              registered stack pointer
//     mem_addr        stack access address
//     mem_we, mem_re  data-memory strobes
//     push_pc_flags   forward mux: select PC/flags
//     half_pc_sel     forward mux: 1 = PC high half
//     flags_sel       forward mux: select {12'b0,flags}
//     busy            sequence in progress
//     pc_out, pc_load restored PC and its one-cycle load strobe
//     flags_out, flags_load  restored flags and their strobe (RTI only)
//     stack_fault     bounds fault pulse (macro builds only)
module stack_push_pop_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              call_req,
  input  logic              rti_req,
  input  logic              ret_req,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic              push_pc_flags,
  output logic              half_pc_sel,
  output logic              flags_sel,
  output logic              busy,
  output logic [31:0]       pc_out,
  output logic              pc_load,
  output logic [3:0]        flags_out,
  output logic              flags_load
`ifdef STACK_BOUNDS_CHECK_EN
  ,
  output logic              stack_fault
`endif
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FL, POP_FL, POP_LO, POP_HI, POP_WB
  } stateT;

  stateT       state, nextState;
  logic        withFlags;    // INT or RTI: the sequence includes the flags word
  logic [15:0] pcLo;
  logic [31:0] pcHeld;
  logic [3:0]  flagsHeld;
  logic        isPush, isPop, faultNow;

  assign isPush = (state == PUSH_HI) || (state == PUSH_LO) || (state == PUSH_FL);
  assign isPop  = (state == POP_FL)  || (state == POP_LO)  || (state == POP_HI);

`ifdef STACK_BOUNDS_CHECK_EN
  assign faultNow = (isPush && (sp == '0)) || (isPop && (sp == SP_RESET));
`else
  assign faultNow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (int_req || call_req) nextState = PUSH_HI;
        else if (rti_req)        nextState = POP_FL;
        else if (ret_req)        nextState = POP_LO;
      end
      PUSH_HI: nextState = PUSH_LO;
      PUSH_LO: nextState = withFlags ? PUSH_FL : IDLE;
      PUSH_FL: nextState = IDLE;
      POP_FL:  nextState = POP_LO;
      POP_LO:  nextState = POP_HI;
      POP_HI:  nextState = POP_WB;
      POP_WB:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (faultNow) nextState = IDLE;
  end

  // Pop data arrives one cycle after its read. Flags land in POP_LO, PCL lands
  // in POP_HI, and PCH lands in POP_WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= SP_RESET;
      withFlags <= 1'b0;
      pcLo      <= '0;
      pcHeld    <= '0;
      flagsHeld <= '0;
    end else begin
      if (state == IDLE)
        withFlags <= int_req || (!call_req && rti_req);
      if (isPush && !faultNow) sp <= sp - 1'b1;
      if (isPop && !faultNow)  sp <= sp + 1'b1;
      if (state == POP_LO && withFlags) flagsHeld <= mem_rdata[3:0];
      if (state == POP_HI) pcLo <= mem_rdata;
      if (state == POP_WB) pcHeld <= {mem_rdata, pcLo};
    end
  end

  always_comb begin
    mem_addr      = isPop ? sp + 1'b1 : sp;
    mem_we        = isPush && !faultNow;
    mem_re        = isPop && !faultNow;
    push_pc_flags = isPush;
    half_pc_sel   = (state == PUSH_HI);
    flags_sel     = (state == PUSH_FL);
    busy          = (state != IDLE);
    pc_load       = (state == POP_WB);
    flags_load    = (state == POP_WB) && withFlags;
    // PCH is still on the read bus during the load strobe, so forward it directly.
    pc_out        = (state == POP_WB) ? {mem_rdata, pcLo} : pcHeld;
    flags_out     = flagsHeld;
`ifdef STACK_BOUNDS_CHECK_EN
    stack_fault   = faultNow;
`endif
  end

endmodule

// File: tb/tb_stack_push_pop_sequencer.sv
module tb_stack_push_pop_sequencer;

  logic        clk = 1'b0;
  logic        rst, int_req, call_req, rti_req, ret_req;
  logic [15:0] mem_rdata;
  logic [15:0] sp, mem_addr;
  logic        mem_we, mem_re, push_pc_flags, half_pc_sel, flags_sel, busy;
  logic [31:0] pc_out;
  logic        pc_load, flags_load;
  logic [3:0]  flags_out;
`ifdef STACK_BOUNDS_CHECK_EN
  logic        stack_fault;
`endif

  localparam logic [15:0] PCH   = 16'h1234;
  localparam logic [15:0] PCL   = 16'h5678;
  localparam logic [3:0]  FLAGS = 4'hA;

  logic [15:0] mem [0:65535];
  logic [15:0] wdata;
  int unsigned nChecks = 0;
  int unsigned nPassed = 0;

  always #5 clk = ~clk;

  stack_push_pop_sequencer #(.ADDR_W(16), .SP_RESET(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .call_req(call_req),
    .rti_req(rti_req), .ret_req(ret_req), .mem_rdata(mem_rdata),
    .sp(sp), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .push_pc_flags(push_pc_flags), .half_pc_sel(half_pc_sel),
    .flags_sel(flags_sel), .busy(busy), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load)
`ifdef STACK_BOUNDS_CHECK_EN
    , .stack_fault(stack_fault)
`endif
  );

  // The write-data mux that sits downstream of the sequencer.
  always_comb begin
    if (!push_pc_flags) wdata = 16'hDEAD;
    else if (flags_sel) wdata = {12'b0, FLAGS};
    else                wdata = half_pc_sel ? PCH : PCL;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[0] = 16'hBEEF;
    mem[1] = 16'hCAFE;
    mem_rdata = '0;
    rst = 1'b1; int_req = 0; call_req = 0; rti_req = 0; ret_req = 0;
    repeat (2) tick();
    check("rst_sp", sp, 32'hFFFF);
    check("rst_busy", busy, 0);
    check("rst_strobes", {mem_we, mem_re, push_pc_flags, half_pc_sel, flags_sel, pc_load, flags_load}, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_flags_out", flags_out, 0);
    rst = 1'b0;

    // CALL from sp=FFFF, with a call_req during busy that must be dropped.
    call_req = 1; tick(); call_req = 1;
    check("call_hi_busy", busy, 1);
    check("call_hi_addr", mem_addr, 32'hFFFF);
    check("call_hi_sel", {mem_we, push_pc_flags, half_pc_sel, flags_sel}, 4'b1110);
    tick(); call_req = 0;
    check("call_lo_addr", mem_addr, 32'hFFFE);
    check("call_lo_sel", {mem_we, push_pc_flags, half_pc_sel, flags_sel}, 4'b1100);
    tick();
    check("call_end_sp", sp, 32'hFFFD);
    check("call_end_busy", busy, 0);
    check("call_mem_hi", mem[16'hFFFF], PCH);
    check("call_mem_lo", mem[16'hFFFE], PCL);
    tick();
    check("call_ignored", {busy, mem_we}, 0);

    rst = 1; tick(); rst = 0;
    check("rst2_sp", sp, 32'hFFFF);

    // Simultaneous int/call/ret: INT wins.
    int_req = 1; call_req = 1; ret_req = 1; tick();
    int_req = 0; call_req = 0; ret_req = 0;
    check("int_hi", {mem_addr, mem_we, half_pc_sel, flags_sel}, {16'hFFFF, 3'b110});
    tick();
    check("int_lo", {mem_addr, mem_we, half_pc_sel, flags_sel}, {16'hFFFE, 3'b100});
    tick();
    check("int_fl", {mem_addr, mem_we, half_pc_sel, flags_sel, busy}, {16'hFFFD, 4'b1011});
    tick();
    check("int_end", {sp, busy, mem_we}, {16'hFFFC, 2'b00});
    check("int_mem_fl", mem[16'hFFFD], 32'h000A);

    // RTI restores what INT pushed.
    rti_req = 1; tick(); rti_req = 0;
    check("rti_fl", {mem_addr, mem_re, mem_we, pc_load}, {16'hFFFD, 3'b100});
    tick();
    check("rti_lo", {mem_addr, mem_re}, {16'hFFFE, 1'b1});
    tick();
    check("rti_hi", {mem_addr, mem_re}, {16'hFFFF, 1'b1});
    tick();
    check("rti_wb_ld", {mem_re, pc_load, flags_load, busy}, 4'b0111);
    check("rti_wb_pc", pc_out, 32'h12345678);
    check("rti_wb_fl", flags_out, 32'hA);
    tick();
    check("rti_end", {busy, pc_load, flags_load}, 0);
    check("rti_hold_pc", pc_out, 32'h12345678);
    check("rti_end_sp", sp, 32'hFFFF);

    // RET with sp=FFFF: wraps, or faults when bounds checking is built in.
    ret_req = 1; tick(); ret_req = 0;
`ifdef STACK_BOUNDS_CHECK_EN
    check("ret_fault", {stack_fault, mem_re, sp}, {2'b10, 16'hFFFF});
    tick();
    check("ret_fault_end", {busy, stack_fault, pc_load, sp}, {3'b000, 16'hFFFF});
`else
    check("ret_lo", {mem_addr, mem_re}, {16'h0000, 1'b1});
    tick();
    check("ret_hi", {mem_addr, mem_re}, {16'h0001, 1'b1});
    tick();
    check("ret_wb", {pc_load, flags_load, pc_out}, {2'b10, 32'hCAFEBEEF});
    check("ret_keep_flags", flags_out, 32'hA);
    tick();
    check("ret_end_sp", {sp, busy}, {16'h0001, 1'b0});
`endif

    // Reset in PUSH_LO aborts the CALL.
    rst = 1; tick(); rst = 0;
    call_req = 1; tick(); call_req = 0;
    tick();
    check("abort_lo", {mem_addr, mem_we}, {16'hFFFE, 1'b1});
    rst = 1; tick();
    check("abort_rst", {sp, busy, mem_we, pc_load}, {16'hFFFF, 3'b000});
    rst = 0; tick();
    check("abort_after", {sp, busy, mem_we}, {16'hFFFF, 2'b00});

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
